// File: rtl/hist_train_pkg.sv
// Shared types and constants for the training-histogram port sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hist_train_pkg;

  // Pass sequencer states; encoding is fixed so debug taps read consistently.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HCU_RUN = 3'd1,
    ST_SWITCH  = 3'd2,
    ST_DCU_RUN = 3'd3,
    ST_FINISH  = 3'd4
  } state_e;

  // Train-port mux select encoding; also reused as the err_phase encoding.
  localparam logic SEL_HCU = 1'b0;
  localparam logic SEL_DCU = 1'b1;

  localparam int unsigned GUARD_DEFAULT   = 2;
  localparam int unsigned TIMEOUT_DEFAULT = 2097152;
  localparam int unsigned CNT_W_DEFAULT   = 22;

  // The DCU owns the port from the guard bubble until the pass closes.
  function automatic logic sel_for(input state_e s);
    return ((s == ST_SWITCH) || (s == ST_DCU_RUN) || (s == ST_FINISH)) ? SEL_DCU : SEL_HCU;
  endfunction

endpackage

// File: rtl/hist_phase_timer.sv
// Per-phase cycle counter with saturation and watchdog expiry compare.
// Latency: count visible the cycle after clr/en; expired is a decode of the registered count.
// Backpressure: none; counts whenever en is high, clr has priority.
module hist_phase_timer
  import hist_train_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             expired
);

  // TIMEOUT of zero turns the watchdog off entirely.
  localparam bit               WD_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over count; the count sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign expired = WD_EN && (cnt_q == LAST);

endmodule

// File: rtl/hist_train_sched.sv
// Sequences one training pass: HCU build, guard bubble, DCU readout, done/err report.
// Latency: hcu_start one cycle after start; dcu_start GUARD cycles after the edge that takes hcu_done.
// Backpressure: none; start is dropped while busy, abort forces IDLE on the next edge.
module hist_train_sched
  import hist_train_pkg::*;
#(
  parameter int unsigned GUARD   = GUARD_DEFAULT,   // 1..15 idle cycles at the handover
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT, // 0 disables the watchdog
  parameter int unsigned CNT_W   = CNT_W_DEFAULT    // must be wide enough for TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             hcu_done,
  input  logic             dcu_done,
  output logic             sel,
  output logic             hcu_start,
  output logic             dcu_start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             err_phase,
  output logic [CNT_W-1:0] phase_cnt
);

  // Guard counter loads GUARD-1 so that SWITCH lasts exactly GUARD cycles.
  localparam logic [3:0] GUARD_M1 = 4'(GUARD - 1);

  state_e     state_q, state_d;
  logic [3:0] guard_q, guard_d;
  logic       sel_q, sel_d;
  logic       hcu_start_q, hcu_start_d;
  logic       dcu_start_q, dcu_start_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       err_phase_q, err_phase_d;

  logic       timer_clr;
  logic       timer_en;
  logic       timer_expired;

  hist_phase_timer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .en      (timer_en),
    .cnt     (phase_cnt),
    .expired (timer_expired)
  );

  // Next-state and next-output decode; abort overrides every transition,
  // and a phase's own done input beats its watchdog in the same cycle.
  always_comb begin
    state_d     = state_q;
    guard_d     = guard_q;
    err_d       = err_q;
    err_phase_d = err_phase_q;
    hcu_start_d = 1'b0;
    dcu_start_d = 1'b0;
    timer_clr   = 1'b0;
    timer_en    = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d     = ST_HCU_RUN;
            hcu_start_d = 1'b1;
            err_d       = 1'b0;
            timer_clr   = 1'b1;
          end
        end
        ST_HCU_RUN: begin
          timer_en = 1'b1;
          if (hcu_done) begin
            state_d = ST_SWITCH;
            guard_d = GUARD_M1;
          end else if (timer_expired) begin
            state_d     = ST_IDLE;
            err_d       = 1'b1;
            err_phase_d = SEL_HCU;
          end
        end
        ST_SWITCH: begin
          // Port is quiet here; stray done pulses from either unit are ignored.
          if (guard_q == 4'd0) begin
            state_d     = ST_DCU_RUN;
            dcu_start_d = 1'b1;
            timer_clr   = 1'b1;
          end else begin
            guard_d = guard_q - 4'd1;
          end
        end
        ST_DCU_RUN: begin
          timer_en = 1'b1;
          if (dcu_done) begin
            state_d = ST_FINISH;
          end else if (timer_expired) begin
            state_d     = ST_IDLE;
            err_d       = 1'b1;
            err_phase_d = SEL_DCU;
          end
        end
        ST_FINISH: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Registered outputs follow the state being entered, so they line up with it.
    sel_d  = sel_for(state_d);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FINISH);
  end

  // State and output registers; reset hands the port back to the HCU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      guard_q     <= 4'd0;
      sel_q       <= SEL_HCU;
      hcu_start_q <= 1'b0;
      dcu_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_phase_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      guard_q     <= guard_d;
      sel_q       <= sel_d;
      hcu_start_q <= hcu_start_d;
      dcu_start_q <= dcu_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_phase_q <= err_phase_d;
    end
  end

  assign sel       = sel_q;
  assign hcu_start = hcu_start_q;
  assign dcu_start = dcu_start_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_phase = err_phase_q;

endmodule

// File: tb/tb_hist_train_sched.sv
// Bench for hist_train_sched: three configurations share one stimulus stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_hist_train_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic hcu_done = 1'b0;
  logic dcu_done = 1'b0;

  always #5 clk = ~clk;

  // A: GUARD=2 TIMEOUT=24; B: GUARD=4 TIMEOUT=8; C: GUARD=1 watchdog off (saturation).
  logic sel_a, hs_a, ds_a, busy_a, done_a, err_a, eph_a;
  logic sel_b, hs_b, ds_b, busy_b, done_b, err_b, eph_b;
  logic sel_c, hs_c, ds_c, busy_c, done_c, err_c, eph_c;
  logic [7:0] cnt_a;
  logic [3:0] cnt_b;
  logic [3:0] cnt_c;

  hist_train_sched #(.GUARD(2), .TIMEOUT(24), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .hcu_done(hcu_done), .dcu_done(dcu_done),
    .sel(sel_a), .hcu_start(hs_a), .dcu_start(ds_a), .busy(busy_a),
    .done(done_a), .err(err_a), .err_phase(eph_a), .phase_cnt(cnt_a));

  hist_train_sched #(.GUARD(4), .TIMEOUT(8), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .hcu_done(hcu_done), .dcu_done(dcu_done),
    .sel(sel_b), .hcu_start(hs_b), .dcu_start(ds_b), .busy(busy_b),
    .done(done_b), .err(err_b), .err_phase(eph_b), .phase_cnt(cnt_b));

  hist_train_sched #(.GUARD(1), .TIMEOUT(0), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .hcu_done(hcu_done), .dcu_done(dcu_done),
    .sel(sel_c), .hcu_start(hs_c), .dcu_start(ds_c), .busy(busy_c),
    .done(done_c), .err(err_c), .err_phase(eph_c), .phase_cnt(cnt_c));

  int nvec = 0;
  int nfail = 0;

  // Reference model: phase 0=idle 1=HCU build 2=guard 3=DCU readout 4=finish.
  int G[3]    = '{2, 4, 1};
  int T[3]    = '{24, 8, 0};
  int CMAX[3] = '{255, 15, 15};
  int m_ph[3];
  int m_gl[3];
  int m_cnt[3];
  bit m_hs[3];
  bit m_ds[3];
  bit m_err[3];
  bit m_eph[3];

  typedef struct {
    int       n;
    bit       s;
    bit       hd;
    bit       dd;
    bit       ab;
    bit [4:0] exp;   // {sel, hcu_start, dcu_start, busy, done} of dut_a
  } row_t;
  row_t tbl[10];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ph[k] = 0; m_gl[k] = 0; m_cnt[k] = 0;
      m_hs[k] = 0; m_ds[k] = 0; m_err[k] = 0; m_eph[k] = 0;
    end
  endtask

  task automatic model_step(input bit s, input bit a, input bit hd, input bit dd);
    for (int k = 0; k < 3; k++) begin
      int ph;
      bit fin;
      bit to;
      ph = m_ph[k];
      m_hs[k] = 0;
      m_ds[k] = 0;
      if (!rst_n) begin
        m_ph[k] = 0; m_gl[k] = 0; m_cnt[k] = 0; m_err[k] = 0; m_eph[k] = 0;
      end else if (a) begin
        m_ph[k] = 0;
      end else if (ph == 0) begin
        if (s) begin
          m_ph[k] = 1; m_hs[k] = 1; m_err[k] = 0; m_cnt[k] = 0;
        end
      end else if (ph == 1 || ph == 3) begin
        fin = (ph == 1) ? hd : dd;
        to  = (T[k] != 0) && (m_cnt[k] == T[k] - 1);
        if (m_cnt[k] < CMAX[k]) m_cnt[k] = m_cnt[k] + 1;
        if (fin) begin
          m_ph[k] = ph + 1;
          m_gl[k] = G[k];
        end else if (to) begin
          m_err[k] = 1; m_eph[k] = (ph == 3); m_ph[k] = 0;
        end
      end else if (ph == 2) begin
        // m_gl counts guard cycles still to spend in the bubble
        m_gl[k] = m_gl[k] - 1;
        if (m_gl[k] == 0) begin
          m_ph[k] = 3; m_ds[k] = 1; m_cnt[k] = 0;
        end
      end else begin
        m_ph[k] = 0;
      end
    end
  endtask

  function automatic logic [14:0] mexp(int k);
    bit sel_e;
    sel_e = (m_ph[k] >= 2);
    return {sel_e, m_hs[k], m_ds[k], m_ph[k] != 0, m_ph[k] == 4, m_err[k], m_eph[k], 8'(m_cnt[k])};
  endfunction

  function automatic logic [14:0] obs(int k);
    case (k)
      0:       return {sel_a, hs_a, ds_a, busy_a, done_a, err_a, eph_a, cnt_a};
      1:       return {sel_b, hs_b, ds_b, busy_b, done_b, err_b, eph_b, 4'b0, cnt_b};
      default: return {sel_c, hs_c, ds_c, busy_c, done_c, err_c, eph_c, 4'b0, cnt_c};
    endcase
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    nvec++;
    if (got != want) begin
      nfail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, want);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      logic [14:0] g;
      logic [14:0] e;
      g = obs(k);
      e = mexp(k);
      nvec++;
      if (g !== e) begin
        nfail++;
        $display("FAIL model_cmp dut%0d t=%0t got=%h exp=%h", k, $time, g, e);
      end
    end
  endtask

  // Check the current cycle's outputs, then drive this cycle's inputs.
  task automatic tick(input bit s, input bit a, input bit hd, input bit dd);
    @(negedge clk);
    check_all();
    start = s; abort = a; hcu_done = hd; dcu_done = dd;
    model_step(s, a, hd, dd);
  endtask

  task automatic run_table();
    for (int i = 0; i < 10; i++) begin
      for (int r = 0; r < tbl[i].n; r++) begin
        tick(tbl[i].s && r == 0, tbl[i].ab && r == 0, tbl[i].hd && r == 0, tbl[i].dd && r == 0);
        chk("nominal_a", {sel_a, hs_a, ds_a, busy_a, done_a}, int'(tbl[i].exp));
      end
    end
  endtask

  initial begin
    //            n  s  hd dd ab  {sel,hs,ds,busy,done}
    tbl[0] = '{1,  1, 0, 0, 0, 5'b00000};  // c0 start
    tbl[1] = '{1,  0, 0, 0, 0, 5'b01010};  // c1 hcu_start
    tbl[2] = '{8,  0, 0, 0, 0, 5'b00010};  // c2..9
    tbl[3] = '{1,  0, 1, 0, 0, 5'b00010};  // c10 hcu_done
    tbl[4] = '{2,  0, 0, 0, 0, 5'b10010};  // c11..12 guard
    tbl[5] = '{1,  0, 0, 0, 0, 5'b10110};  // c13 dcu_start
    tbl[6] = '{16, 0, 0, 0, 0, 5'b10010};  // c14..29
    tbl[7] = '{1,  0, 0, 1, 0, 5'b10010};  // c30 dcu_done
    tbl[8] = '{1,  0, 0, 0, 0, 5'b10011};  // c31 done
    tbl[9] = '{2,  0, 0, 0, 0, 5'b00000};  // c32..33 idle

    model_reset();
    #1;
    for (int k = 0; k < 3; k++) chk("reset_state", int'(obs(k)), 0);
    #11 rst_n = 1'b1;

    run_table();

    // HCU watchdog on B: err at cycle 9, phase HCU, back to idle.
    for (int c = 0; c <= 9; c++) begin
      tick(c == 0, 0, 0, 0);
      if (c == 8) chk("hcu_to_cnt7", {busy_b, cnt_b}, {1'b1, 4'd7});
      if (c == 9) chk("hcu_to_err", {err_b, eph_b, busy_b, sel_b, done_b}, 5'b10000);
    end
    repeat (30) tick(0, 0, 0, 0);

    // New start clears err; then DCU watchdog on B.
    for (int c = 0; c <= 15; c++) begin
      tick(c == 0, 0, c == 2, 0);
      if (c == 0)  chk("err_held", err_b, 1);
      if (c == 1)  chk("start_clr_err", {err_b, hs_b}, 2'b01);
      if (c == 6)  chk("guard_b_quiet", {sel_b, ds_b}, 2'b10);
      if (c == 7)  chk("dcu_start_b", {sel_b, ds_b, cnt_b}, 6'b110000);
      if (c == 15) chk("dcu_to_err", {err_b, eph_b, sel_b, busy_b}, 4'b1100);
    end
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);

    // Abort while B sits in the guard bubble.
    for (int c = 0; c <= 12; c++) begin
      tick(c == 0, c == 4, c == 2, 0);
      if (c == 3) chk("switch_b", {sel_b, busy_b}, 2'b11);
      if (c == 5) chk("abort_b", {sel_b, busy_b, err_b, cnt_b}, 7'b0000010);
      if (c >= 5) chk("no_dcu_start", ds_b, 0);
    end

    // Illegal events on A: start while busy, hcu_done in DCU, dcu_done on the timeout cycle.
    for (int c = 0; c <= 44; c++) begin
      tick(c == 0 || c == 15, 0, c == 16 || c == 22, c == 42);
      if (c == 1)  chk("hcu_start_a", hs_a, 1);
      if (c == 16) chk("start_ignored", {hs_a, cnt_a}, {1'b0, 8'd15});
      if (c == 19) chk("dcu_start_a", ds_a, 1);
      if (c == 23) chk("hd_in_dcu", {sel_a, busy_a, ds_a, done_a}, 4'b1100);
      if (c == 42) chk("to_cycle_cnt", cnt_a, 23);
      if (c == 43) chk("done_beats_to", {done_a, err_a}, 2'b10);
      if (c == 44) chk("idle_after", {busy_a, sel_a}, 2'b00);
    end

    // Asynchronous reset mid DCU readout, then a fresh nominal pass.
    for (int c = 0; c <= 23; c++) begin
      tick(c == 0, 0, c == 5, 0);
      if (c == 20) begin
        chk("pre_rst_busy", {sel_a, busy_a}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_a", int'(obs(0)), 0);
        chk("async_rst_b", int'(obs(1)), 0);
        chk("async_rst_c", int'(obs(2)), 0);
        model_reset();
      end
      if (c == 23) #2 rst_n = 1'b1;
    end
    run_table();

    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end
    tick(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
